spi_slave_ctrl: RTL and testbench
=================================

# spi_slave_ctrl

Serial front end of the SPI slave: deserialises MOSI frames into 10-bit command words for the single-port RAM (`rx_data`/`rx_valid`) and, on a read-data command, serialises the RAM's returned byte (`tx_data`/`tx_valid`) onto MISO. It sits between the SPI pins and the RAM inside the SPI wrapper. `clk` is the SPI clock.

## Interface
- MEM_WIDTH, 8, width of RAM data; the command word is MEM_WIDTH+2 bits wide.
- clk  in  1  clock; all logic samples on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- SS_n  in  1  slave select, active-low; framing.
- MOSI  in  1  serial command/data in, MSB first.
- MISO  out  1  serial read data out, MSB first.
- rx_data  out  MEM_WIDTH+2  command word to the RAM; [9:8] is the opcode, [7:0] is the address or data.
- rx_valid  out  1  one-cycle strobe; `rx_data` is valid while it is high.
- tx_data  in  MEM_WIDTH  read byte from the RAM.
- tx_valid  in  1  strobe from the RAM; `tx_data` is valid while it is high.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Internal `rd_addr_done` flag (reset 0). 4-bit bit counter. 10-bit receive shift register. 8-bit transmit shift register.
- IDLE: SS_n sampled low -> CHK_CMD. No MOSI bit is captured in this cycle.
- CHK_CMD: if SS_n is high -> IDLE. Otherwise sample MOSI as bit 9:
  - bit 9 = 0 -> WRITE.
  - bit 9 = 1 and `rd_addr_done` = 0 -> READ_ADD.
  - bit 9 = 1 and `rd_addr_done` = 1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift in 9 more MOSI bits (bits 8..0), one per cycle.
  - On the edge that samples bit 0, register `rx_data` = the full 10-bit word and set `rx_valid` = 1 for exactly one cycle.
  - `rx_data` holds until the next completed frame.
- The opcode in `rx_data[9:8]` is passed through exactly as received. The slave never rewrites it.
- READ_ADD: set `rd_addr_done` = 1 on the `rx_valid` edge.
- WRITE / READ_ADD, after the strobe: idle in the same state until SS_n goes high -> IDLE.
- READ_DATA, after the strobe: wait for `tx_valid` with no timeout.
  - On the edge `tx_valid` is sampled high: load `tx_data`, drive MISO = `tx_data[7]`.
  - Drive bits 6..0 on the following 7 edges.
  - MISO returns to 0 after the 8th bit cycle.
  - `rd_addr_done` clears when the 8th bit is driven.
  - `tx_valid` is ignored outside the READ_DATA wait phase.
- Abort: SS_n sampled high in any non-IDLE state -> IDLE on that edge.
  - No `rx_valid` unless bit 0 was already captured.
  - MISO forced to 0.
  - `rd_addr_done` keeps its value, except a completed READ_DATA transmit still clears it.
- Back-to-back frames: the earliest next frame start is SS_n low on the cycle after return to IDLE.

## Timing
- Reset values: MISO 0, `rx_data` 0, `rx_valid` 0, state IDLE, `rd_addr_done` 0, counters 0.
- Reset dominates all other inputs on any edge, including mid-frame and mid-transmit.
- Edge numbering, with SS_n sampled low at edge E0:
  - Bit 9 is sampled at E1.
  - Bits 8..0 are sampled at E2..E10.
  - `rx_valid` is high between E10 and E11.
- Frame latency: 11 clk edges from SS_n low to `rx_valid`.
- With a RAM responding in 1 cycle:
  - `tx_valid` is high between E11 and E12.
  - MISO bit 7 is valid after E12; bit 0 after E19.
  - SS_n may rise at or after E20.
- `rx_valid` is never high for two consecutive cycles.

## Test plan
- Write address: reset, then frame 0b00_0010_1010 -> `rx_data` = 0x02A, `rx_valid` high 1 cycle at E10–E11, MISO stays 0.
- Write data: frame 0b01_1100_0011 -> `rx_data` = 0x1C3, state WRITE, `rd_addr_done` stays 0.
- Read address then read data:
  - Frame 0b10_0010_1010 -> `rx_data` = 0x22A, `rd_addr_done` = 1.
  - Next frame 0b11_0000_0000 -> `rx_data` = 0x300.
  - Model returns `tx_valid` with 0xC3 one cycle later -> MISO = 1,1,0,0,0,0,1,1 on E12..E19, then `rd_addr_done` = 0.
- Abort: SS_n rises after bit 5 of a WRITE frame -> no `rx_valid`, IDLE next edge; the following full frame 0x055 is received correctly.
- Reset mid-transmit: rst_n low during MISO bit 4 -> next edge MISO 0, state IDLE, `rd_addr_done` 0.
- Stray `tx_valid` pulse in IDLE or WRITE -> MISO stays 0, no state change.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave serial front end: shifts MOSI frames into RAM command words and
// serialises the RAM read byte onto MISO after a read-data command.
module spi_slave_ctrl #(
    parameter int MEM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [MEM_WIDTH+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [MEM_WIDTH-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int W = MEM_WIDTH + 2;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    // Sub-phase within WRITE/READ_ADD/READ_DATA.
    localparam logic [1:0] PH_RX   = 2'd0;
    localparam logic [1:0] PH_WAIT = 2'd1;
    localparam logic [1:0] PH_TX   = 2'd2;
    localparam logic [1:0] PH_DONE = 2'd3;

    localparam logic [3:0] RX_LAST = 4'(MEM_WIDTH);
    localparam logic [3:0] TX_LAST = 4'(MEM_WIDTH - 1);

    logic [2:0]           state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [W-2:0]         rx_sr_q, rx_sr_d;
    logic [MEM_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [W-1:0]         rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 miso_q, miso_d;
    logic                 rd_addr_done_q, rd_addr_done_d;

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        rx_sr_d        = rx_sr_q;
        tx_sr_d        = tx_sr_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = miso_q;
        rd_addr_done_d = rd_addr_done_q;

        if (state_q == IDLE) begin
            cnt_d   = 4'd0;
            phase_d = PH_RX;
            miso_d  = 1'b0;
            if (!SS_n) begin
                state_d = CHK_CMD;
            end
        end else if (SS_n) begin
            // Abort: a frame cut short before bit 0 never strobes.
            state_d = IDLE;
            phase_d = PH_RX;
            cnt_d   = 4'd0;
            miso_d  = 1'b0;
        end else if (state_q == CHK_CMD) begin
            rx_sr_d = {{(W - 2){1'b0}}, MOSI};
            cnt_d   = 4'd0;
            phase_d = PH_RX;
            if (!MOSI) begin
                state_d = WRITE;
            end else if (rd_addr_done_q) begin
                state_d = READ_DATA;
            end else begin
                state_d = READ_ADD;
            end
        end else begin
            case (phase_q)
                PH_RX: begin
                    rx_sr_d = {rx_sr_q[W-3:0], MOSI};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == RX_LAST) begin
                        rx_data_d  = {rx_sr_q, MOSI};
                        rx_valid_d = 1'b1;
                        cnt_d      = 4'd0;
                        if (state_q == READ_ADD) begin
                            rd_addr_done_d = 1'b1;
                        end
                        phase_d = (state_q == READ_DATA) ? PH_WAIT : PH_DONE;
                    end
                end
                PH_WAIT: begin
                    if (tx_valid) begin
                        miso_d  = tx_data[MEM_WIDTH-1];
                        tx_sr_d = {tx_data[MEM_WIDTH-2:0], 1'b0};
                        cnt_d   = 4'd0;
                        phase_d = PH_TX;
                    end
                end
                PH_TX: begin
                    if (cnt_q == TX_LAST) begin
                        miso_d  = 1'b0;
                        phase_d = PH_DONE;
                    end else begin
                        miso_d  = tx_sr_q[MEM_WIDTH-1];
                        tx_sr_d = {tx_sr_q[MEM_WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q + 4'd1;
                        // This edge drives the last data bit.
                        if (cnt_q == TX_LAST - 4'd1) begin
                            rd_addr_done_d = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            phase_q        <= PH_RX;
            cnt_q          <= 4'd0;
            rx_sr_q        <= '0;
            tx_sr_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            rx_sr_q        <= rx_sr_d;
            tx_sr_q        <= tx_sr_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            rd_addr_done_q <= rd_addr_done_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: table of frames driven bit-serially, rx words
// scoreboarded through a queue, MISO compared every cycle.
module tb_spi_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    spi_slave_ctrl #(.MEM_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        bit         has_tx;
        logic [7:0] tx;
        bit         stray;
        int         nbits;
    } vec_t;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [9:0] exp_q[$];
    logic       exp_miso = 1'b0;
    logic [9:0] last_rx = 10'h000;
    logic       prev_rv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        #1;
        if (rx_valid) begin
            check("rx_valid_pulse", {31'd0, prev_rv}, 32'd0);
            if (exp_q.size() == 0) begin
                check("rx_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", {22'd0, rx_data}, {22'd0, e});
                last_rx = e;
            end
        end
        check("miso", {31'd0, MISO}, {31'd0, exp_miso});
        prev_rv = rx_valid;
    endtask

    task automatic stray_pulse();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // nbits < 10 aborts the frame; rst_mid resets while MISO carries bit 4.
    task automatic send_frame(input vec_t v, input bit rst_mid);
        check("rx_hold", {22'd0, rx_data}, {22'd0, last_rx});
        if (v.stray) stray_pulse();
        SS_n     = 1'b0;
        exp_miso = 1'b0;
        tick();
        if (v.nbits == 10) exp_q.push_back(v.frame);
        for (int i = 9; i > 9 - v.nbits; i--) begin
            MOSI = v.frame[i];
            tick();
        end
        MOSI = 1'b0;
        check("rx_pending", exp_q.size(), 32'd0);
        if (v.nbits == 10) begin
            if (v.stray && !v.has_tx) stray_pulse();
            tick();
            if (v.has_tx) begin
                tx_data  = v.tx;
                tx_valid = 1'b1;
                for (int k = 7; k >= 0; k--) begin
                    if (rst_mid && k == 3) begin
                        rst_n    = 1'b0;
                        SS_n     = 1'b1;
                        exp_miso = 1'b0;
                        tick();
                        rst_n   = 1'b1;
                        last_rx = 10'h000;
                        return;
                    end
                    exp_miso = v.tx[k];
                    tick();
                    tx_valid = 1'b0;
                end
                exp_miso = 1'b0;
                tick();
            end
        end
        SS_n = 1'b1;
        tick();
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{frame: 10'h02A, has_tx: 0, tx: 8'h00, stray: 1, nbits: 10};
        vecs[1]  = '{frame: 10'h1C3, has_tx: 0, tx: 8'h00, stray: 0, nbits: 10};
        vecs[2]  = '{frame: 10'h22A, has_tx: 0, tx: 8'h00, stray: 0, nbits: 10};
        vecs[3]  = '{frame: 10'h300, has_tx: 1, tx: 8'hC3, stray: 0, nbits: 10};
        vecs[4]  = '{frame: 10'h0FF, has_tx: 0, tx: 8'h00, stray: 0, nbits: 5};
        vecs[5]  = '{frame: 10'h055, has_tx: 0, tx: 8'h00, stray: 0, nbits: 10};
        vecs[6]  = '{frame: 10'h3A0, has_tx: 0, tx: 8'h00, stray: 1, nbits: 10};
        vecs[7]  = '{frame: 10'h35A, has_tx: 1, tx: 8'h5A, stray: 0, nbits: 10};
        vecs[8]  = '{frame: 10'h2AA, has_tx: 0, tx: 8'h00, stray: 0, nbits: 10};
        vecs[9]  = '{frame: 10'h3F0, has_tx: 0, tx: 8'h00, stray: 1, nbits: 10};
        vecs[10] = '{frame: 10'h311, has_tx: 1, tx: 8'h81, stray: 0, nbits: 10};

        tick();
        tick();
        check("reset_miso", {31'd0, MISO}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", {22'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 9; n++) send_frame(vecs[n], 1'b0);

        // Reset in the middle of a transmit, then confirm the read-address
        // flag was cleared: the next 0b11 frame must not transmit.
        send_frame('{frame: 10'h3AA, has_tx: 1, tx: 8'h96, stray: 0, nbits: 10}, 1'b1);
        check("rst_mid_miso", {31'd0, MISO}, 32'd0);
        check("rst_mid_rx_data", {22'd0, rx_data}, 32'd0);
        check("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
        tick();
        send_frame(vecs[9], 1'b0);
        send_frame(vecs[10], 1'b0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
